// File: rtl/set_job_sched.sv
// set_job_sched: two-requester round-robin front end for the shared SET
// counting engine. It grants one job at a time, pulses the engine start,
// returns the candidate count to the job owner and counts completed jobs.
// Optional feature: define SET_TIMEOUT_EN to enable the RUN-state watchdog.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request while the engine is not busy
// ISSUE  | grant pulse to the owner, start pulse to the engine
// RUN    | waiting for engine valid (or watchdog expiry)
// DONE   | response pulse to the owner, result held on rsp_data
module set_job_sched #(
  parameter logic [7:0] TIMEOUT = 8'd127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] mode0,
  input  logic [1:0] mode1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       eng_en,
  output logic [1:0] eng_mode,
  input  logic       eng_busy,
  input  logic       eng_valid,
  input  logic [7:0] eng_candidate,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last;
  logic   win;
  logic   start;
  logic   finish;
  logic   timeout_hit;

  // Round-robin winner: the lone requester, or the one not served last.
  assign win    = (req0 & req1) ? ~last : req1;
  assign start  = (state == S_IDLE) & (req0 | req1) & ~eng_busy;
  assign finish = (state == S_RUN) & (eng_valid | timeout_hit);

`ifdef SET_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog counts RUN cycles; cleared while the job is being issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= 8'd0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= 8'd0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Expiry on the TIMEOUT-th RUN cycle; a coincident valid takes priority.
  assign timeout_hit = (state == S_RUN) & ~eng_valid & (wd_cnt == (TIMEOUT - 8'd1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job bookkeeping: owner/mode latch at grant, result and counters at finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      eng_mode  <= 2'b00;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
      jobs_done <= 8'd0;
    end else begin
      if (start) begin
        owner    <= win;
        eng_mode <= win ? mode1 : mode0;
      end
      if (finish) begin
        rsp_data  <= eng_valid ? eng_candidate : 8'hFF;
        rsp_err   <= timeout_hit;
        jobs_done <= jobs_done + 8'd1;
        last      <= owner;
      end
    end
  end

  // Pulse outputs decoded from registered state and owner only.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    eng_en     = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    if (state == S_ISSUE) begin
      eng_en = 1'b1;
      gnt0   = ~owner;
      gnt1   = owner;
    end
    if (state == S_DONE) begin
      rsp_valid0 = ~owner;
      rsp_valid1 = owner;
    end
  end

endmodule

// File: tb/tb_set_job_sched.sv
// Self-checking bench for set_job_sched: bench-side engine responses,
// round-robin reference model and a scoreboard of expected responses.
module tb_set_job_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] mode0 = 2'b00;
  logic [1:0] mode1 = 2'b00;
  logic       eng_busy = 1'b0;
  logic       eng_valid = 1'b0;
  logic [7:0] eng_candidate = 8'd0;
  logic       gnt0, gnt1, eng_en, rsp_valid0, rsp_valid1, rsp_err;
  logic [1:0] eng_mode;
  logic [7:0] rsp_data, jobs_done;

`ifdef SET_TIMEOUT_EN
  set_job_sched #(.TIMEOUT(8'd10)) dut (
`else
  set_job_sched dut (
`endif
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1), .eng_en(eng_en), .eng_mode(eng_mode),
    .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       owner;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       last_m = 1'b1;
  logic [7:0] jobs_m = 8'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    check("rsp_seen", {31'd0, rsp_valid0 | rsp_valid1}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_owner", {30'd0, rsp_valid1, rsp_valid0}, e.owner ? 32'd2 : 32'd1);
      check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      jobs_m  = jobs_m + 8'd1;
      last_m  = e.owner;
      check("jobs_done", {24'd0, jobs_done}, {24'd0, jobs_m});
    end else begin
      check("sb_empty", 32'd1, 32'd0);
    end
  endtask

  // Called at a falling edge with the scheduler in IDLE; returns in IDLE.
  task automatic run_job(input logic r0, input logic r1, input logic [1:0] m0,
                         input logic [1:0] m1, input int busy_cyc, input int lat,
                         input logic [7:0] data);
    logic w;
    exp_t e;
    req0 = r0; req1 = r1; mode0 = m0; mode1 = m1;
    eng_busy = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      @(negedge clk);
      check("busy_hold", {29'd0, gnt0, gnt1, eng_en}, 32'd0);
    end
    eng_busy = 1'b0;
    w = (r0 & r1) ? ~last_m : r1;
    e.owner = w; e.data = data; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    check("gnt", {30'd0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
    check("eng_en", {31'd0, eng_en}, 32'd1);
    check("eng_mode", {30'd0, eng_mode}, {30'd0, (w ? m1 : m0)});
    if (w) req1 = 1'b0; else req0 = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("run_quiet", {27'd0, gnt0, gnt1, eng_en, rsp_valid0, rsp_valid1}, 32'd0);
      check("mode_hold", {30'd0, eng_mode}, {30'd0, (w ? m1 : m0)});
    end
    eng_valid = 1'b1; eng_candidate = data;
    @(negedge clk);
    eng_valid = 1'b0;
    check_rsp();
    @(negedge clk);
    check("idle_quiet", {27'd0, gnt0, gnt1, eng_en, rsp_valid0, rsp_valid1}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {7'd0, gnt0, gnt1, eng_en, eng_mode, rsp_valid0, rsp_valid1,
                rsp_data, rsp_err, jobs_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;

    // single requester, engine returns 37
    run_job(1'b1, 1'b0, 2'b11, 2'b00, 0, 2, 8'd37);
    // both requesters held: alternating grants
    run_job(1'b1, 1'b1, 2'b01, 2'b10, 0, 1, 8'd11);
    run_job(1'b1, 1'b1, 2'b00, 2'b11, 0, 3, 8'd200);
    run_job(1'b1, 1'b1, 2'b10, 2'b01, 0, 2, 8'd5);
    // engine busy holds off the grant
    run_job(1'b0, 1'b1, 2'b00, 2'b10, 4, 1, 8'd99);

`ifdef SET_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      req0 = 1'b1; mode0 = 2'b01; req1 = 1'b0;
      e.owner = 1'b0; e.data = 8'hFF; e.err = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      check("to_gnt", {31'd0, gnt0}, 32'd1);
      req0 = 1'b0;
      n = 0;
      while (!(rsp_valid0 | rsp_valid1) && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_rsp();
      @(negedge clk);
    end
`endif

    // reset in RUN abandons the job
    req0 = 1'b1; mode0 = 2'b10; req1 = 1'b0;
    @(negedge clk);
    check("pre_rst_gnt", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_job_reset");
    rst = 1'b0;
    jobs_m = 8'd0; last_m = 1'b1;
    eng_valid = 1'b1; eng_candidate = 8'd55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_valid", {28'd0, rsp_valid0, rsp_valid1, gnt0, eng_en}, 32'd0);
    end
    eng_valid = 1'b0;
    @(negedge clk);

    // 256 random jobs: counter wraps back to zero
    for (int j = 0; j < 256; j++) begin
      int r;
      r = $urandom_range(1, 3);
      run_job(r[0], r[1], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 2 : 0, $urandom_range(1, 4),
              8'($urandom_range(0, 255)));
    end
    check("jobs_wrap", {24'd0, jobs_done}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
